tick_rate_ctrl: RTL and testbench

//  Controller for the 4:1 count-rate selection of the 8-bit up/down counter lab design.

---
 rtl/tick_rate_ctrl_pkg.sv | 23 ++
 rtl/tick_rate_ctrl_if.sv | 12 +
 rtl/tick_rate_ctrl_sw_sync_filter.sv | 42 ++++
 rtl/tick_rate_ctrl.sv | 89 ++++++++
 tb/tb_tick_rate_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_rate_ctrl_pkg.sv
// Shared definitions for the count-rate controller: default rate exponents,
// debounce length, FSM state encoding and the rate-mask helper.
package tick_rate_ctrl_pkg;

    localparam int DEF_DIV_EXP0   = 1;
    localparam int DEF_DIV_EXP1   = 2;
    localparam int DEF_DIV_EXP2   = 3;
    localparam int DEF_DIV_EXP3   = 4;
    localparam int DEF_STABLE_CYC = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    typedef logic [1:0] rate_sel_t;

    // Low-bit mask whose all-ones match marks the last cycle of a 2^exp period.
    function automatic logic [31:0] rate_mask(input int exp_v);
        return (32'd1 << exp_v) - 32'd1;
    endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// Rate-select switch in, tick enable and selection status out.
interface tick_rate_ctrl_if;

    logic [1:0] sw;
    logic       tick;
    logic [1:0] sel_active;
    logic       pending;

    modport master (output sw, input tick, input sel_active, input pending);
    modport slave  (input sw, output tick, output sel_active, output pending);

endinterface

// File: rtl/tick_rate_ctrl_sw_sync_filter.sv
// Two-flop synchroniser for the raw rate switch followed by a stability counter;
// a value is offered to the controller only after it has held STABLE_CYC cycles.
module sw_sync_filter
    import tick_rate_ctrl_pkg::*;
#(
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic      clk,
    input  logic      rst,
    input  rate_sel_t sw,
    output rate_sel_t cand,
    output logic      stable
);

    localparam int SCW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYC - 1);

    rate_sel_t      sw_m;
    rate_sel_t      sw_s;
    logic [SCW-1:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m     <= '0;
            sw_s     <= '0;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            if (sw_s != cand) begin
                cand     <= sw_s;
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    assign stable = (stab_cnt == STAB_MAX);

endmodule

// File: rtl/tick_rate_ctrl.sv
// Four-rate tick generator: free-running prescaler, registered tick and a
// rate-switch FSM that only commits a new selection at the prescaler wrap.
//
//   state   | meaning
//   ST_RUN  | ticking at sel_active, no change requested
//   ST_PEND | req_sel accepted, waiting for prescaler wrap to commit it
module tick_rate_ctrl
    import tick_rate_ctrl_pkg::*;
#(
    parameter int DIV_EXP0   = DEF_DIV_EXP0,
    parameter int DIV_EXP1   = DEF_DIV_EXP1,
    parameter int DIV_EXP2   = DEF_DIV_EXP2,
    parameter int DIV_EXP3   = DEF_DIV_EXP3,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input logic             clk,
    input logic             rst,
    tick_rate_ctrl_if.slave bus
);

    localparam int W = DIV_EXP3;
    localparam logic [W-1:0] MASK0 = W'(rate_mask(DIV_EXP0));
    localparam logic [W-1:0] MASK1 = W'(rate_mask(DIV_EXP1));
    localparam logic [W-1:0] MASK2 = W'(rate_mask(DIV_EXP2));
    localparam logic [W-1:0] MASK3 = W'(rate_mask(DIV_EXP3));

    logic [W-1:0] cnt;
    logic [3:0]   hit;
    logic         wrap;
    rate_sel_t    cand;
    logic         stable;
    rate_sel_t    req_sel;
    rate_sel_t    sel_active;
    logic         tick;
    state_t       state;

    sw_sync_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_sw_filter (
        .clk    (clk),
        .rst    (rst),
        .sw     (bus.sw),
        .cand   (cand),
        .stable (stable)
    );

    assign hit[0] = ((cnt & MASK0) == MASK0);
    assign hit[1] = ((cnt & MASK1) == MASK1);
    assign hit[2] = ((cnt & MASK2) == MASK2);
    assign hit[3] = ((cnt & MASK3) == MASK3);
    // All faster rates also hit here, so switching at wrap never truncates a period.
    assign wrap   = hit[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            tick       <= 1'b0;
            req_sel    <= '0;
            sel_active <= '0;
            state      <= ST_RUN;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= hit[sel_active];
            case (state)
                ST_RUN: begin
                    if (stable && (cand != sel_active)) begin
                        req_sel <= cand;
                        state   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (wrap) begin
                        sel_active <= req_sel;
                        state      <= ST_RUN;
                    end else if (stable && (cand == sel_active)) begin
                        state <= ST_RUN;
                    end else if (stable && (cand != req_sel)) begin
                        req_sel <= cand;
                    end
                end
            endcase
        end
    end

    assign bus.tick       = tick;
    assign bus.sel_active = sel_active;
    assign bus.pending    = (state == ST_PEND);

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed and randomised checks of tick_rate_ctrl against a cycle model built
// from period arithmetic and consecutive-sample counting.
module tb_tick_rate_ctrl;

    localparam int E0 = 1, E1 = 2, E2 = 3, E3 = 4;
    localparam int STAB = 4;
    localparam int PRESC = 1 << E3;

    logic       clk;
    logic       rst;
    logic [1:0] drv_sw;
    int         checks;
    int         failures;

    tick_rate_ctrl_if bus ();
    assign bus.sw = drv_sw;

    tick_rate_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int exps[4] = '{E0, E1, E2, E3};
    int m_cnt, m_s1, m_s2, m_cand, m_same, m_req, m_sel, m_pend, m_tick;

    task automatic model_step(input int sw_in, input logic r);
        int  period;
        bit  wrap, stable, nt;
        if (r) begin
            m_cnt = 0; m_s1 = 0; m_s2 = 0; m_cand = 0; m_same = 0;
            m_req = 0; m_sel = 0; m_pend = 0; m_tick = 0;
            return;
        end
        period = 1 << exps[m_sel];
        nt     = ((m_cnt + 1) % period) == 0;
        wrap   = ((m_cnt + 1) % PRESC) == 0;
        stable = (m_same == STAB - 1);
        if (m_pend == 0) begin
            if (stable && m_cand != m_sel) begin
                m_req = m_cand; m_pend = 1;
            end
        end else if (wrap) begin
            m_sel = m_req; m_pend = 0;
        end else if (stable && m_cand == m_sel) begin
            m_pend = 0;
        end else if (stable && m_cand != m_req) begin
            m_req = m_cand;
        end
        if (m_s2 != m_cand) begin
            m_cand = m_s2; m_same = 0;
        end else begin
            m_same = (m_same + 1 > STAB - 1) ? STAB - 1 : m_same + 1;
        end
        m_s2   = m_s1;
        m_s1   = sw_in;
        m_cnt  = (m_cnt + 1) % PRESC;
        m_tick = nt ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(int'(drv_sw), rst);
        #1;
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("sel_active", 32'(bus.sel_active), 32'(m_sel));
        chk("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic wait_tick(input string tag, input int exp_gap, input int max);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.tick !== 1'b1 && n < max);
        chk(tag, 32'(n), 32'(exp_gap));
    endtask

    task automatic wait_pending(input logic val, input int max);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.pending !== val && n < max);
        chk("pending_wait", 32'(bus.pending), 32'(val));
    endtask

    task automatic wait_sel(input logic [1:0] val, input int max);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.sel_active !== val && n < max);
        chk("sel_wait", 32'(bus.sel_active), 32'(val));
    endtask

    task automatic align_wrap();
        while (m_cnt != 0) cyc();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drv_sw = 2'd0;
        model_step(0, 1'b1);

        // 1: reset, then rate 0
        repeat (3) cyc();
        chk("rst_tick", 32'(bus.tick), 32'd0);
        chk("rst_sel", 32'(bus.sel_active), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        rst = 1'b0;
        wait_tick("r0_first_gap", 2, 10);
        wait_tick("r0_gap", 2, 10);
        wait_tick("r0_gap", 2, 10);

        // 2: switch to rate 3
        drv_sw = 2'd3;
        wait_pending(1'b1, 20);
        wait_sel(2'd3, 40);
        chk("wrap_tick_old_rate", 32'(bus.tick), 32'd1);
        wait_tick("r3_first_gap", 16, 40);
        wait_tick("r3_gap", 16, 40);

        // 3: bounce never reaches the FSM
        rst = 1'b1; drv_sw = 2'd0;
        repeat (2) cyc();
        rst = 1'b0;
        drv_sw = 2'd1; repeat (2) cyc();
        drv_sw = 2'd0; repeat (2) cyc();
        repeat (20) begin
            cyc();
            chk("bounce_pending", 32'(bus.pending), 32'd0);
        end
        chk("bounce_sel", 32'(bus.sel_active), 32'd0);
        wait_tick("bounce_gap", 2, 10);

        // 4: abort before wrap
        align_wrap();
        drv_sw = 2'd2;
        wait_pending(1'b1, 20);
        drv_sw = 2'd0;
        wait_pending(1'b0, 20);
        repeat (20) cyc();
        chk("abort_sel", 32'(bus.sel_active), 32'd0);

        // 5: retarget while pending
        align_wrap();
        drv_sw = 2'd1;
        wait_pending(1'b1, 20);
        drv_sw = 2'd2;
        wait_sel(2'd2, 30);
        chk("retarget_pending", 32'(bus.pending), 32'd0);

        // 6: reset while pending
        drv_sw = 2'd3;
        wait_pending(1'b1, 20);
        rst = 1'b1; drv_sw = 2'd0;
        cyc();
        chk("rstp_pending", 32'(bus.pending), 32'd0);
        chk("rstp_sel", 32'(bus.sel_active), 32'd0);
        chk("rstp_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        wait_tick("rstp_first_gap", 2, 10);

        // 7: randomised switch activity with occasional resets
        repeat (300) begin
            drv_sw = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(1, 12)) begin
                cyc();
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
